// File: rtl/expr_eval_pkg.sv
// Shared encodings for the streaming expression evaluator: FSM states,
// ASCII constants and the character classes produced by the classifier.
package expr_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_NUM  = 2'd1;
    localparam logic [1:0] ST_OP   = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_EQ    = 8'h3D;

    typedef enum logic [2:0] {
        CLS_DIGIT,
        CLS_OP_ADD,
        CLS_OP_SUB,
        CLS_OP_MUL,
        CLS_EQ,
        CLS_ILLEGAL
    } char_class_t;

endpackage

// File: rtl/expr_eval_if.sv
// Character stream in, expression status and values out.
interface expr_eval_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic [7:0]   in;
    logic         out;
    logic [W-1:0] value;
    logic         err;
    logic         done;
    logic         done_ok;
    logic [W-1:0] result;

    modport master (
        output in_valid, in,
        input  out, value, err, done, done_ok, result
    );

    modport slave (
        input  in_valid, in,
        output out, value, err, done, done_ok, result
    );
endinterface

// File: rtl/expr_classify.sv
// Maps one ASCII character to its class and, for digits, its numeric value.
module expr_classify
    import expr_pkg::*;
#(
    parameter int ALLOW_SUB = 1
) (
    input  logic [7:0]  in,
    output char_class_t cls,
    output logic [3:0]  digit
);

    // '0'..'9' sit at 0x30..0x39, so the low nibble is already the digit value.
    always_comb begin
        cls   = CLS_ILLEGAL;
        digit = 4'd0;
        if (in >= CH_0 && in <= CH_9) begin
            cls   = CLS_DIGIT;
            digit = in[3:0];
        end else begin
            case (in)
                CH_PLUS:  cls = CLS_OP_ADD;
                CH_STAR:  cls = CLS_OP_MUL;
                CH_MINUS: cls = (ALLOW_SUB != 0) ? CLS_OP_SUB : CLS_ILLEGAL;
                CH_EQ:    cls = CLS_EQ;
                default:  cls = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/expr_eval.sv
// Streaming arithmetic expression evaluator: one ASCII character per valid
// cycle, '*' binds tighter than '+'/'-', all arithmetic modulo 2^W.
module expr_eval
    import expr_pkg::*;
#(
    parameter int W          = 32,
    parameter int MAX_DIGITS = 9,
    parameter int ALLOW_SUB  = 1
) (
    input logic        clk,
    input logic        clr,
    expr_eval_if.slave bus
);
    localparam int NW = $clog2(MAX_DIGITS + 1);

    logic [1:0]    state_q, state_n;
    logic [W-1:0]  sum_q, sum_n;
    logic [W-1:0]  term_q, term_n;
    logic [W-1:0]  cur_q, cur_n;
    logic [NW-1:0] ndig_q, ndig_n;
    logic          sign_q, sign_n;
    logic [W-1:0]  value_q, value_n;
    logic [W-1:0]  result_q, result_n;
    logic          done_q, done_n;
    logic          done_ok_q, done_ok_n;

    char_class_t   cls;
    logic [3:0]    digit;
    logic [W-1:0]  prod;
    logic [W-1:0]  folded;
    logic [W-1:0]  cur_x10;

    expr_classify #(.ALLOW_SUB(ALLOW_SUB)) u_classify (
        .in    (bus.in),
        .cls   (cls),
        .digit (digit)
    );

    // folded is the expression value with the number in progress applied;
    // sign_q=1 means the pending term is subtracted.
    assign prod    = term_q * cur_q;
    assign folded  = sign_q ? (sum_q - prod) : (sum_q + prod);
    assign cur_x10 = cur_q * W'(10);

    always_comb begin
        state_n   = state_q;
        sum_n     = sum_q;
        term_n    = term_q;
        cur_n     = cur_q;
        ndig_n    = ndig_q;
        sign_n    = sign_q;
        result_n  = result_q;
        done_n    = 1'b0;
        done_ok_n = 1'b0;

        if (bus.in_valid) begin
            case (cls)
                CLS_DIGIT: begin
                    if (state_q == ST_IDLE || state_q == ST_OP) begin
                        state_n = ST_NUM;
                        cur_n   = W'(digit);
                        ndig_n  = NW'(1);
                    end else if (state_q == ST_NUM) begin
                        if (ndig_q == NW'(MAX_DIGITS)) begin
                            state_n = ST_ERR;
                        end else begin
                            cur_n  = cur_x10 + W'(digit);
                            ndig_n = ndig_q + NW'(1);
                        end
                    end
                end
                CLS_OP_ADD, CLS_OP_SUB: begin
                    if (state_q == ST_NUM) begin
                        state_n = ST_OP;
                        sum_n   = folded;
                        term_n  = W'(1);
                        cur_n   = '0;
                        ndig_n  = '0;
                        sign_n  = (cls == CLS_OP_SUB);
                    end else begin
                        state_n = ST_ERR;
                    end
                end
                CLS_OP_MUL: begin
                    if (state_q == ST_NUM) begin
                        state_n = ST_OP;
                        term_n  = prod;
                        cur_n   = '0;
                        ndig_n  = '0;
                    end else begin
                        state_n = ST_ERR;
                    end
                end
                CLS_EQ: begin
                    state_n   = ST_IDLE;
                    done_n    = 1'b1;
                    done_ok_n = (state_q == ST_NUM);
                    result_n  = (state_q == ST_NUM) ? folded : '0;
                    sum_n     = '0;
                    term_n    = W'(1);
                    cur_n     = '0;
                    ndig_n    = '0;
                    sign_n    = 1'b0;
                end
                default: state_n = ST_ERR;
            endcase
        end

        value_n = sign_n ? (sum_n - term_n * cur_n) : (sum_n + term_n * cur_n);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            sum_q     <= '0;
            term_q    <= W'(1);
            cur_q     <= '0;
            ndig_q    <= '0;
            sign_q    <= 1'b0;
            value_q   <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            done_ok_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            sum_q     <= sum_n;
            term_q    <= term_n;
            cur_q     <= cur_n;
            ndig_q    <= ndig_n;
            sign_q    <= sign_n;
            value_q   <= value_n;
            result_q  <= result_n;
            done_q    <= done_n;
            done_ok_q <= done_ok_n;
        end
    end

    assign bus.out     = (state_q == ST_NUM);
    assign bus.err     = (state_q == ST_ERR);
    assign bus.value   = value_q;
    assign bus.result  = result_q;
    assign bus.done    = done_q;
    assign bus.done_ok = done_ok_q;

endmodule

// File: tb/tb_expr_eval.sv
// Directed bench for expr_eval: one shared character stream feeds four
// instances (default, MAX_DIGITS=3, ALLOW_SUB=0, W=8), each test checks its own.
module tb_expr_eval;

    logic       clk;
    logic       clr;
    logic       in_valid;
    logic [7:0] ch;

    int vectors;
    int miscompares;

    expr_eval_if #(.W(32)) ifd ();
    expr_eval_if #(.W(32)) ifm ();
    expr_eval_if #(.W(32)) ifn ();
    expr_eval_if #(.W(8))  ifw ();

    assign ifd.in_valid = in_valid;
    assign ifd.in       = ch;
    assign ifm.in_valid = in_valid;
    assign ifm.in       = ch;
    assign ifn.in_valid = in_valid;
    assign ifn.in       = ch;
    assign ifw.in_valid = in_valid;
    assign ifw.in       = ch;

    expr_eval #(.W(32), .MAX_DIGITS(9), .ALLOW_SUB(1)) u_def (.clk(clk), .clr(clr), .bus(ifd));
    expr_eval #(.W(32), .MAX_DIGITS(3), .ALLOW_SUB(1)) u_md3 (.clk(clk), .clr(clr), .bus(ifm));
    expr_eval #(.W(32), .MAX_DIGITS(9), .ALLOW_SUB(0)) u_ns  (.clk(clk), .clr(clr), .bus(ifn));
    expr_eval #(.W(8),  .MAX_DIGITS(9), .ALLOW_SUB(1)) u_w8  (.clk(clk), .clr(clr), .bus(ifw));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one character for exactly one rising edge; returns #1 after it.
    task automatic send(input logic [7:0] c);
        @(negedge clk);
        in_valid = 1'b1;
        ch       = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ch       = 8'h20;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        #2;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        #2;
        clr = 1'b1;
        #1;
        vectors++;
        if ({ifd.out, ifd.err, ifd.done, ifd.done_ok} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b, want 0000", {ifd.out, ifd.err, ifd.done, ifd.done_ok});
        end
        vectors++;
        if (ifd.value !== 32'd0 || ifd.result !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got value=%0d result=%0d, want 0/0", ifd.value, ifd.result);
        end
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_expression();
        string s = "1+3*90";
        logic  exp_out [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        int    exp_val [6] = '{1, 1, 4, 1, 28, 271};
        do_clr();
        for (int i = 0; i < 6; i++) begin
            send(s[i]);
            vectors++;
            if (ifd.out !== exp_out[i] || ifd.err !== 1'b0 || ifd.value !== 32'(exp_val[i])) begin
                miscompares++;
                $display("[TB] FAIL expr_step%0d: got out=%0d err=%0d value=%0d, want out=%0d err=0 value=%0d",
                         i, ifd.out, ifd.err, ifd.value, exp_out[i], exp_val[i]);
            end
        end
    endtask

    task automatic test_done();
        string s = "12*3-4";
        int    exp_val [6] = '{1, 12, 0, 36, 36, 32};
        do_clr();
        for (int i = 0; i < 6; i++) begin
            send(s[i]);
            vectors++;
            if (ifd.value !== 32'(exp_val[i])) begin
                miscompares++;
                $display("[TB] FAIL done_step%0d: got value=%0d, want %0d", i, ifd.value, exp_val[i]);
            end
        end
        send("=");
        vectors++;
        if (ifd.done !== 1'b1 || ifd.done_ok !== 1'b1 || ifd.result !== 32'd32) begin
            miscompares++;
            $display("[TB] FAIL done_pulse: got done=%0d ok=%0d result=%0d, want 1/1/32",
                     ifd.done, ifd.done_ok, ifd.result);
        end
        idle_cycle();
        vectors++;
        if (ifd.done !== 1'b0 || ifd.out !== 1'b0 || ifd.value !== 32'd0 || ifd.result !== 32'd32) begin
            miscompares++;
            $display("[TB] FAIL done_after: got done=%0d out=%0d value=%0d result=%0d, want 0/0/0/32",
                     ifd.done, ifd.out, ifd.value, ifd.result);
        end
    endtask

    // Runs straight after test_done so result starts at 32 and must clear.
    task automatic test_error();
        send("+");
        vectors++;
        if (ifd.err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL err_after_plus: got %0d, want 1", ifd.err);
        end
        send("1");
        vectors++;
        if (ifd.err !== 1'b1 || ifd.out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL err_sticky: got err=%0d out=%0d, want 1/0", ifd.err, ifd.out);
        end
        send("=");
        vectors++;
        if (ifd.done !== 1'b1 || ifd.done_ok !== 1'b0 || ifd.result !== 32'd0 || ifd.err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL err_eq: got done=%0d ok=%0d result=%0d err=%0d, want 1/0/0/0",
                     ifd.done, ifd.done_ok, ifd.result, ifd.err);
        end
        send("&");
        vectors++;
        if (ifd.err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL err_illegal: got %0d, want 1", ifd.err);
        end
    endtask

    task automatic test_max_digits();
        do_clr();
        send_str("123");
        vectors++;
        if (ifm.err !== 1'b0 || ifm.out !== 1'b1 || ifm.value !== 32'd123) begin
            miscompares++;
            $display("[TB] FAIL md3_three: got err=%0d out=%0d value=%0d, want 0/1/123", ifm.err, ifm.out, ifm.value);
        end
        send("4");
        vectors++;
        if (ifm.err !== 1'b1 || ifm.out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL md3_fourth: got err=%0d out=%0d, want 1/0", ifm.err, ifm.out);
        end
        vectors++;
        if (ifd.err !== 1'b0 || ifd.value !== 32'd1234) begin
            miscompares++;
            $display("[TB] FAIL md9_four: got err=%0d value=%0d, want 0/1234", ifd.err, ifd.value);
        end
        do_clr();
        send_str("999999999");
        vectors++;
        if (ifd.err !== 1'b0 || ifd.value !== 32'd999999999) begin
            miscompares++;
            $display("[TB] FAIL md9_nine: got err=%0d value=%0d, want 0/999999999", ifd.err, ifd.value);
        end
        send("9");
        vectors++;
        if (ifd.err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL md9_tenth: got err=%0d, want 1", ifd.err);
        end
    endtask

    task automatic test_no_sub();
        do_clr();
        send_str("5-");
        vectors++;
        if (ifn.err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL nosub_minus: got err=%0d, want 1", ifn.err);
        end
        vectors++;
        if (ifd.err !== 1'b0 || ifd.value !== 32'd5) begin
            miscompares++;
            $display("[TB] FAIL sub_minus: got err=%0d value=%0d, want 0/5", ifd.err, ifd.value);
        end
        send_str("7=");
        vectors++;
        if (ifd.result !== 32'hFFFFFFFE || ifd.done_ok !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sub_wrap: got result=%0h ok=%0d, want fffffffe/1", ifd.result, ifd.done_ok);
        end
    endtask

    task automatic test_wrap();
        do_clr();
        send_str("200+100=");
        vectors++;
        if (ifw.result !== 8'd44 || ifw.done_ok !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL w8_result: got result=%0d ok=%0d, want 44/1", ifw.result, ifw.done_ok);
        end
        vectors++;
        if (ifd.result !== 32'd300) begin
            miscompares++;
            $display("[TB] FAIL w32_result: got %0d, want 300", ifd.result);
        end
    endtask

    task automatic test_back_to_back();
        do_clr();
        send_str("2*3+4*5=");
        vectors++;
        if (ifd.done !== 1'b1 || ifd.done_ok !== 1'b1 || ifd.result !== 32'd26) begin
            miscompares++;
            $display("[TB] FAIL b2b_first: got done=%0d ok=%0d result=%0d, want 1/1/26", ifd.done, ifd.done_ok, ifd.result);
        end
        send("=");
        vectors++;
        if (ifd.done !== 1'b1 || ifd.done_ok !== 1'b0 || ifd.result !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL b2b_second: got done=%0d ok=%0d result=%0d, want 1/0/0", ifd.done, ifd.done_ok, ifd.result);
        end
    endtask

    task automatic test_idle_gaps();
        do_clr();
        send("9");
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            vectors++;
            if (ifd.out !== 1'b1 || ifd.value !== 32'd9 || ifd.err !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL gap_num%0d: got out=%0d value=%0d err=%0d, want 1/9/0", i, ifd.out, ifd.value, ifd.err);
            end
        end
        send("+");
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            vectors++;
            if (ifd.out !== 1'b0 || ifd.value !== 32'd9 || ifd.err !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL gap_op%0d: got out=%0d value=%0d err=%0d, want 0/9/0", i, ifd.out, ifd.value, ifd.err);
            end
        end
    endtask

    task automatic test_async_clr();
        do_clr();
        send_str("4=");
        send_str("7*8");
        vectors++;
        if (ifd.value !== 32'd56 || ifd.result !== 32'd4 || ifd.out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pre_clr: got value=%0d result=%0d out=%0d, want 56/4/1", ifd.value, ifd.result, ifd.out);
        end
        #2;
        clr = 1'b1;
        #1;
        vectors++;
        if (ifd.value !== 32'd0 || ifd.result !== 32'd0 || ifd.out !== 1'b0 || ifd.err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_clr: got value=%0d result=%0d out=%0d err=%0d, want 0/0/0/0",
                     ifd.value, ifd.result, ifd.out, ifd.err);
        end
        #1;
        clr = 1'b0;
        send("5");
        vectors++;
        if (ifd.value !== 32'd5 || ifd.out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL post_clr: got value=%0d out=%0d, want 5/1", ifd.value, ifd.out);
        end
        send("=");
        #2;
        clr = 1'b1;
        #1;
        vectors++;
        if (ifd.done !== 1'b0 || ifd.done_ok !== 1'b0 || ifd.result !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL clr_done: got done=%0d ok=%0d result=%0d, want 0/0/0", ifd.done, ifd.done_ok, ifd.result);
        end
        #1;
        clr = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        in_valid    = 1'b0;
        ch          = 8'h20;
        test_reset();
        test_expression();
        test_done();
        test_error();
        test_max_digits();
        test_no_sub();
        test_wrap();
        test_back_to_back();
        test_idle_gaps();
        test_async_clr();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
